// File: rtl/scan_chain_ctrl_pkg.sv
// scan_pkg: shared types and helpers for the scan chain sequencer.
//   scan_state_t : sequencer FSM states
//   cnt_w()      : bit-counter width for a given chain length (minimum 1)
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CAPT  = 2'd2,
      UNLD  = 2'd3
   } scan_state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: request/result bundle of the scan sequencer.
//   START/PAT/EXP     : run request with pattern and expected response
//   BUSY/DONE/RESP/FAIL : status and unloaded result
//   master = requester side, slave = sequencer side
interface scan_chain_ctrl_if #(parameter int CHAIN_LEN = 32);

   logic                 START;
   logic [CHAIN_LEN-1:0] PAT;
   logic [CHAIN_LEN-1:0] EXP;
   logic                 BUSY;
   logic                 DONE;
   logic [CHAIN_LEN-1:0] RESP;
   logic                 FAIL;

   modport master (output START, PAT, EXP, input BUSY, DONE, RESP, FAIL);
   modport slave  (input START, PAT, EXP, output BUSY, DONE, RESP, FAIL);

endinterface

// File: rtl/scan_chain_ctrl_shift_reg.sv
// scan_shift_reg: W-bit register with parallel load and left shift.
//   CLK, RST : clock, async active-high reset (clears q)
//   ld/ld_val: parallel load (wins over shift)
//   sh/sin   : shift left one bit, sin enters at bit 0
//   q        : register contents
module scan_shift_reg #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         sh,
   input  logic         sin,
   output logic [W-1:0] q
);

   logic [W-1:0] nxt;

   generate
      if (W == 1) begin : g_one
         assign nxt = sin;
      end else begin : g_many
         assign nxt = {q[W-2:0], sin};
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)     q <= '0;
      else if (ld) q <= ld_val;
      else if (sh) q <= nxt;
   end

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: load / capture / unload sequencer for one mux-scan chain.
//   CLK, RST : clock shared with the chain, async active-high reset
//   bus      : START/PAT/EXP request, BUSY/DONE/RESP/FAIL result
//   SDOUT    : Q of the last chain flop
//   SSEL     : scan enable to all chain flops
//   SDIN     : serial data into chain flop 0
// Every output is decoded from registers only.
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN = 32,
   parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
   input  logic              CLK,
   input  logic              RST,
   scan_chain_ctrl_if.slave  bus,
   input  logic              SDOUT,
   output logic              SSEL,
   output logic              SDIN
);

   scan_state_t          state;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] exp_q;
   logic [CHAIN_LEN-1:0] pat_q;
   logic [CHAIN_LEN-1:0] resp_q;
   logic [CHAIN_LEN-1:0] resp_nxt;
   logic                 done_q;
   logic                 fail_q;
   logic                 accept;
   logic                 last;

   assign accept = (state == IDLE) && bus.START;
   assign last   = (cnt == CNT_W'(CHAIN_LEN - 1));

   // Value the response register takes on this edge; FAIL is judged on it
   // so it lines up with DONE.
   generate
      if (CHAIN_LEN == 1) begin : g_nxt_one
         assign resp_nxt = SDOUT;
      end else begin : g_nxt_many
         assign resp_nxt = {resp_q[CHAIN_LEN-2:0], SDOUT};
      end
   endgenerate

   // Pattern serializer: MSB goes out first, zeros refill from the bottom.
   scan_shift_reg #(.W(CHAIN_LEN)) u_pat (
      .CLK    (CLK),
      .RST    (RST),
      .ld     (accept),
      .ld_val (bus.PAT),
      .sh     (state == SHIFT),
      .sin    (1'b0),
      .q      (pat_q)
   );

   // Response deserializer: tail flop arrives first and ends up at the MSB.
   scan_shift_reg #(.W(CHAIN_LEN)) u_resp (
      .CLK    (CLK),
      .RST    (RST),
      .ld     (1'b0),
      .ld_val ('0),
      .sh     (state == UNLD),
      .sin    (SDOUT),
      .q      (resp_q)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         exp_q  <= '0;
         done_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.START) begin
                  exp_q <= bus.EXP;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               cnt <= cnt + 1'b1;
               if (last) state <= CAPT;
            end
            CAPT: begin
               cnt   <= '0;
               state <= UNLD;
            end
            UNLD: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  fail_q <= (resp_nxt != exp_q);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // During UNLD SDIN stays 0 so the chain is left cleared.
   assign SSEL     = (state == SHIFT) || (state == UNLD);
   assign SDIN     = (state == SHIFT) && pat_q[CHAIN_LEN-1];
   assign bus.BUSY = (state != IDLE);
   assign bus.DONE = done_q;
   assign bus.RESP = resp_q;
   assign bus.FAIL = fail_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 8-flop chain model (plus a 1-flop one for the
// CHAIN_LEN=1 instance), table of runs, scoreboard checked at every DONE.
module tb_scan_chain_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // ---- CHAIN_LEN=8 instance and chain model ----
   scan_chain_ctrl_if #(.CHAIN_LEN(8)) bus ();
   logic       ssel, sdin, sdout;
   logic [7:0] chain;
   logic       hold;      // functional DIN = own Q
   logic [7:0] din_val;   // functional DIN when not holding

   scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .SDOUT(sdout), .SSEL(ssel), .SDIN(sdin)
   );

   always @(posedge CLK) chain <= ssel ? {chain[6:0], sdin} : (hold ? chain : din_val);
   assign sdout = chain[7];

   // ---- CHAIN_LEN=1 instance, DIN tied to 0 ----
   scan_chain_ctrl_if #(.CHAIN_LEN(1)) bus1 ();
   logic ssel1, sdin1, c1;

   scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
      .CLK(CLK), .RST(RST), .bus(bus1), .SDOUT(c1), .SSEL(ssel1), .SDIN(sdin1)
   );

   always @(posedge CLK) c1 <= ssel1 ? sdin1 : 1'b0;

   // ---- checking ----
   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt = 0;

   typedef struct { logic [7:0] resp; logic fail; } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] pat; logic [7:0] exp; bit hold; logic [7:0] din;
      logic [7:0] resp; logic fail;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, want);
   endtask

   // Scoreboard: every DONE pulse pops one expectation.
   initial forever begin
      @(negedge CLK);
      if (!RST && bus.DONE) begin
         done_cnt++;
         if (sb.size() == 0) chk("spurious_done", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp", bus.RESP, e.resp);
            chk("fail", bus.FAIL, e.fail);
         end
      end
   end

   // Called just after a negedge; returns at the negedge after the accept edge.
   task automatic launch(input logic [7:0] pat, input logic [7:0] ex);
      bus.START = 1'b1; bus.PAT = pat; bus.EXP = ex;
      @(negedge CLK);
      bus.START = 1'b0; bus.PAT = ~pat; bus.EXP = ~ex;
   endtask

   // Follow a run from negedge k0 (k=0 is right after the accept edge) to DONE.
   task automatic track(input int k0, output int lat,
                        output logic [16:0] ss, output logic [16:0] sd);
      lat = -1; ss = '0; sd = '0;
      for (int k = k0; k < 60; k++) begin
         if (k < 17) begin ss[16-k] = ssel; sd[16-k] = sdin; end
         if (bus.DONE) begin lat = k; break; end
         @(negedge CLK);
      end
      if (lat < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic run_vec(input vec_t v);
      int lat; logic [16:0] ss, sd;
      hold = v.hold; din_val = v.din;
      sb.push_back('{v.resp, v.fail});
      launch(v.pat, v.exp);
      track(0, lat, ss, sd);
      chk("latency", lat, 17);
      chk("ssel_seq", {15'd0, ss}, {15'd0, 17'b11111111_0_11111111});
      chk("sdin_seq", {15'd0, sd}, {15'd0, v.pat, 9'd0});
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      int lat, d0, k;
      logic [16:0] ss, sd;

      tbl[0] = '{8'hA5, 8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b0};
      tbl[1] = '{8'hA5, 8'h3D, 1'b0, 8'h3C, 8'h3C, 1'b1};
      tbl[2] = '{8'h5A, 8'h5A, 1'b1, 8'h00, 8'h5A, 1'b0};
      tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1};

      bus.START = 0; bus.PAT = 0; bus.EXP = 0;
      bus1.START = 0; bus1.PAT = 0; bus1.EXP = 0;
      hold = 0; din_val = 0;

      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_ssel", ssel, 0);
      chk("rst_sdin", sdin, 0);
      chk("rst_busy", bus.BUSY, 0);
      chk("rst_done", bus.DONE, 0);
      chk("rst_resp", bus.RESP, 0);
      chk("rst_fail", bus.FAIL, 0);
      RST = 1'b0;
      @(negedge CLK);

      foreach (tbl[i]) run_vec(tbl[i]);

      // FAIL holds after a mismatching run and through the next run's shift
      run_vec(tbl[1]);
      repeat (4) @(negedge CLK);
      chk("fail_hold_idle", bus.FAIL, 1);
      sb.push_back('{8'h3C, 1'b0});
      launch(8'hA5, 8'h3C);
      repeat (5) @(negedge CLK);
      chk("fail_hold_busy", bus.FAIL, 1);
      chk("busy_mid", bus.BUSY, 1);
      track(5, lat, ss, sd);
      chk("latency_b", lat, 17);
      repeat (2) @(negedge CLK);

      // async reset in SHIFT cycle 3 (SDIN is 1 there for A5)
      launch(8'hA5, 8'h3C);
      repeat (2) @(negedge CLK);
      chk("pre_rst_sdin", sdin, 1);
      #2 RST = 1'b1;
      #1;
      chk("mid_rst_ssel", ssel, 0);
      chk("mid_rst_sdin", sdin, 0);
      chk("mid_rst_busy", bus.BUSY, 0);
      chk("mid_rst_done", bus.DONE, 0);
      chk("mid_rst_resp", bus.RESP, 0);
      @(negedge CLK);
      RST = 1'b0;
      sb.delete();
      @(negedge CLK);
      run_vec(tbl[0]);

      // START during UNLD is ignored
      d0 = done_cnt;
      hold = 0; din_val = 8'h3C;
      sb.push_back('{8'h3C, 1'b0});
      launch(8'hA5, 8'h3C);
      repeat (12) @(negedge CLK);
      bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
      track(13, lat, ss, sd);
      chk("latency_unld_start", lat, 17);
      repeat (25) @(negedge CLK);
      chk("done_pulses", done_cnt - d0, 1);
      chk("idle_after", bus.BUSY, 0);

      // START in the DONE cycle starts a second run
      sb.push_back('{8'h3C, 1'b0});
      launch(8'hA5, 8'h3C);
      track(0, lat, ss, sd);
      chk("latency_r1", lat, 17);
      sb.push_back('{8'h3C, 1'b0});
      launch(8'h5A, 8'h3C);
      chk("b2b_busy", bus.BUSY, 1);
      chk("b2b_done_low", bus.DONE, 0);
      track(0, lat, ss, sd);
      chk("latency_r2", lat, 17);
      chk("sdin_r2", {15'd0, sd}, {15'd0, 8'h5A, 9'd0});
      repeat (3) @(negedge CLK);
      chk("sb_empty", sb.size(), 0);

      // CHAIN_LEN=1
      bus1.START = 1'b1; bus1.PAT = 1'b1; bus1.EXP = 1'b0;
      @(negedge CLK);
      bus1.START = 1'b0; bus1.PAT = 1'b0;
      chk("cl1_ssel_shift", ssel1, 1);
      chk("cl1_sdin_shift", sdin1, 1);
      @(negedge CLK);
      chk("cl1_ssel_capt", ssel1, 0);
      k = 1;
      while (!bus1.DONE && k < 20) begin @(negedge CLK); k++; end
      chk("cl1_latency", k, 3);
      chk("cl1_resp", bus1.RESP, 0);
      chk("cl1_fail", bus1.FAIL, 0);
      @(negedge CLK);
      chk("cl1_idle", bus1.BUSY, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
